// File: rtl/mr1_mem_pkg.sv
// Shared size encoding and byte-lane helpers for the MR1 memory-port model.
package mr1_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    // Size 3 is illegal and falls through to a full-word mask.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size_e'(size))
            SIZE_B:  m = 4'b0001 << addr_lo;
            SIZE_H:  m = 4'b0011 << addr_lo;
            default: m = 4'hF;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        case (size_e'(size))
            SIZE_H:  r = addr_lo[0];
            SIZE_W:  r = (addr_lo != 2'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mr1_mem_port_model_if.sv
// MR1 request (valid/ready) and response (valid-only) bundle.
interface mr1_mem_port_model_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_wr, req_size, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wr, req_size, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mr1_rsp_delay_line.sv
// Fixed-latency valid/data shift register carrying read responses.
module mr1_rsp_delay_line #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);
    logic [LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= in_valid_i;
            data_q[0] <= in_data_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];
endmodule

// File: rtl/mr1_mem_port_model.sv
// Bounded memory responder for one MR1 request/response port pair:
// fixed latency, outstanding-read cap, byte-lane writes, sticky protocol error.
module mr1_mem_port_model #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned WR_EN     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    mr1_mem_port_model_if.slave  bus,
    output logic [3:0]           outstanding,
    output logic                 err
);
    import mr1_mem_pkg::*;

    localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic [3:0]        out_q, out_d;
    logic              err_q, err_d;
    logic              pend_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwr_q;
    logic [1:0]        psize_q;
    logic [DATA_W-1:0] pdata_q;

    logic              ready;
    logic              acc, acc_rd, acc_wr;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        mask;
    logic [DATA_W-1:0] rd_word;
    logic              dl_valid;
    logic [DATA_W-1:0] dl_data;
    logic              req_changed;

    // The cap uses the registered count, so a same-cycle response frees nothing.
    assign ready  = reset_n && !stall && (bus.req_wr || (out_q < DEPTH_C));
    assign acc    = bus.req_valid && ready;
    assign acc_rd = acc && !bus.req_wr;
    assign acc_wr = acc && bus.req_wr;

    assign idx     = bus.req_addr[2 +: IDX_W];
    assign mask    = byte_mask(bus.req_size, bus.req_addr[1:0]);
    assign rd_word = mem_q[idx];

    always_ff @(posedge clk) begin
        if (acc_wr && (WR_EN != 0)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mask[b]) begin
                    mem_q[idx][8*b +: 8] <= bus.req_data[8*b +: 8];
                end
            end
        end
    end

    mr1_rsp_delay_line #(
        .LATENCY (LATENCY),
        .DATA_W  (DATA_W)
    ) u_delay (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (acc_rd),
        .in_data_i   (acc_rd ? rd_word : '0),
        .out_valid_o (dl_valid),
        .out_data_o  (dl_data)
    );

    assign req_changed = (bus.req_addr != paddr_q) || (bus.req_wr != pwr_q) ||
                         (bus.req_size != psize_q) || (pwr_q && (bus.req_data != pdata_q));

    always_comb begin
        err_d = err_q;
        if (acc && (misaligned(bus.req_size, bus.req_addr[1:0]) || (bus.req_size == 2'd3))) begin
            err_d = 1'b1;
        end
        if (pend_q && !bus.req_valid) begin
            err_d = 1'b1;
        end
        if (pend_q && bus.req_valid && req_changed) begin
            err_d = 1'b1;
        end
        if (acc_wr && (WR_EN == 0)) begin
            err_d = 1'b1;
        end
        if (dl_valid && (out_q == 4'd0)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        out_d = out_q;
        case ({acc_rd, dl_valid})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            paddr_q <= '0;
            pwr_q   <= 1'b0;
            psize_q <= '0;
            pdata_q <= '0;
        end else begin
            out_q   <= out_d;
            err_q   <= err_d;
            pend_q  <= bus.req_valid && !ready;
            paddr_q <= bus.req_addr;
            pwr_q   <= bus.req_wr;
            psize_q <= bus.req_size;
            pdata_q <= bus.req_data;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = dl_valid;
    assign bus.rsp_data  = dl_data;
    assign outstanding   = out_q;
    assign err           = err_q;
endmodule

// File: tb/tb_mr1_mem_port_model.sv
// Directed and random checks of mr1_mem_port_model against a transaction-level model.
module tb_mr1_mem_port_model;
    localparam int unsigned LAT = 4;
    localparam int unsigned DEP = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       stall1 = 1'b0;
    logic       stall2 = 1'b0;
    logic [3:0] out1, out2;
    logic       err1, err2;

    mr1_mem_port_model_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mr1_mem_port_model_if #(.ADDR_W(32), .DATA_W(32)) b2 ();

    mr1_mem_port_model #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(256), .LATENCY(LAT), .DEPTH(DEP), .WR_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall1), .bus(b1), .outstanding(out1), .err(err1)
    );

    mr1_mem_port_model #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(256), .LATENCY(1), .DEPTH(1), .WR_EN(0)
    ) dut_ro (
        .clk(clk), .reset_n(reset_n), .stall(stall2), .bus(b2), .outstanding(out2), .err(err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mb [1024];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          err_m = 1'b0;
    bit          pend_m = 1'b0;
    logic [31:0] la = '0;
    bit          lw = 1'b0;
    logic [1:0]  ls = '0;
    logic [31:0] ld = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int w;
        w = int'((addr >> 2) % 256) * 4;
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    // One bus cycle on the WR_EN=1 instance: drive, check, then advance the model.
    task automatic step(input bit v, input bit wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] data, input bit st);
        int  out_exp, lo, w;
        bit  rsp_exp, rdy_exp, acc, e;
        @(negedge clk);
        b1.req_valid = v; b1.req_wr = wr; b1.req_addr = addr;
        b1.req_size = size; b1.req_data = data; stall1 = st;
        #1;
        out_exp = q.size();
        rsp_exp = (q.size() > 0) && (q[0].due == cyc);
        chk("rsp_valid", b1.rsp_valid, rsp_exp);
        if (rsp_exp) chk("rsp_data", b1.rsp_data, q[0].data);
        chk("outstanding", out1, out_exp);
        chk("err", err1, err_m);
        rdy_exp = !st && (wr || out_exp < int'(DEP));
        chk("req_ready", b1.req_ready, rdy_exp);
        if (rsp_exp) void'(q.pop_front());
        acc = v && rdy_exp;
        e = 1'b0;
        if (pend_m && !v) e = 1'b1;
        if (pend_m && v && (addr != la || wr != lw || size != ls || (lw && data != ld))) e = 1'b1;
        if (acc && size == 2'd3) e = 1'b1;
        if (acc && size == 2'd1 && addr[0]) e = 1'b1;
        if (acc && size == 2'd2 && addr[1:0] != 2'd0) e = 1'b1;
        if (acc && !wr) q.push_back('{cyc + int'(LAT), model_word(addr)});
        if (acc && wr) begin
            w  = int'((addr >> 2) % 256) * 4;
            lo = int'(addr % 4);
            for (int k = 0; k < 4; k++) begin
                if ((size == 2'd0 && k == lo) || (size == 2'd1 && (k == lo || k == lo + 1)) || size >= 2'd2)
                    mb[w+k] = data[8*k +: 8];
            end
        end
        err_m  = err_m | e;
        pend_m = v && !rdy_exp;
        la = addr; lw = wr; ls = size; ld = data;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        b1.req_valid = 1'b0; b1.req_wr = 1'b1; stall1 = 1'b0;
        b2.req_valid = 1'b0; b2.req_wr = 1'b1; stall2 = 1'b0;
        #1;
        chk("rst_ready", b1.req_ready, 1'b0);
        chk("rst_rsp_valid", b1.rsp_valid, 1'b0);
        chk("rst_rsp_data", b1.rsp_data, 32'h0);
        chk("rst_outstanding", out1, 4'd0);
        chk("rst_err", err1, 1'b0);
        chk("rst_ro_ready", b2.req_ready, 1'b0);
        chk("rst_ro_err", err2, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        b2.req_wr = 1'b0;
        q.delete();
        err_m = 1'b0;
        pend_m = 1'b0;
        cyc += 2;
    endtask

    initial begin
        bit          v, wr, st;
        logic [1:0]  sz;
        logic [31:0] a, d;
        b1.req_valid = 1'b0; b1.req_wr = 1'b0; b1.req_addr = '0; b1.req_size = '0; b1.req_data = '0;
        b2.req_valid = 1'b0; b2.req_wr = 1'b0; b2.req_addr = '0; b2.req_size = '0; b2.req_data = '0;
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;

        do_reset();
        for (int w = 0; w < 32; w++) step(1'b1, 1'b1, 32'(w * 4), 2'd2, $urandom, 1'b0);
        idle(1);

        // word write, then read of the same word the very next cycle
        step(1'b1, 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 1'b0);
        step(1'b1, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        idle(LAT + 1);

        // byte and half-word lanes
        step(1'b1, 1'b1, 32'h20, 2'd2, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h22, 2'd0, 32'h00AA0000, 1'b0);
        step(1'b1, 1'b1, 32'h20, 2'd1, 32'h00001234, 1'b0);
        step(1'b1, 1'b0, 32'h20, 2'd2, 32'h0, 1'b0);
        idle(LAT + 1);

        // back-to-back reads against the outstanding cap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'(i * 4), 2'd2, 32'h0, 1'b0);
        idle(LAT + 2);

        // WR_EN=0 instance: read latency 1 with depth 1, then a forbidden write
        b2.req_valid = 1'b1; b2.req_wr = 1'b0; b2.req_addr = 32'h0; b2.req_size = 2'd2;
        #1 chk("ro_ready_read", b2.req_ready, 1'b1);
        idle(1);
        chk("ro_rsp_valid", b2.rsp_valid, 1'b1);
        chk("ro_outstanding", out2, 4'd1);
        b2.req_valid = 1'b0;
        #1 chk("ro_ready_capped", b2.req_ready, 1'b0);
        idle(1);
        chk("ro_rsp_done", b2.rsp_valid, 1'b0);
        chk("ro_outstanding0", out2, 4'd0);
        chk("ro_err_clean", err2, 1'b0);
        b2.req_valid = 1'b1; b2.req_wr = 1'b1; b2.req_addr = 32'h4; b2.req_data = 32'h55AA55AA;
        #1 chk("ro_ready_write", b2.req_ready, 1'b1);
        idle(1);
        b2.req_valid = 1'b0; b2.req_wr = 1'b0;
        chk("ro_err_write", err2, 1'b1);
        idle(1);
        chk("ro_err_sticky", err2, 1'b1);

        // misaligned word read: err, response still carries the aligned word
        step(1'b1, 1'b0, 32'h42, 2'd2, 32'h0, 1'b0);
        idle(LAT + 2);

        // valid withdrawn while stalled
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h40, 2'd2, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h40, 2'd2, 32'h0, 1'b1);
        idle(3);

        // address changed while stalled
        do_reset();
        step(1'b1, 1'b0, 32'h40, 2'd2, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h44, 2'd2, 32'h0, 1'b0);
        idle(LAT + 1);

        // reset with three reads in flight
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(16 + i * 4), 2'd2, 32'h0, 1'b0);
        do_reset();
        idle(LAT + 3);

        // legal random traffic with stalls and held requests
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 3) == 0);
            if (pend_m) begin
                step(1'b1, lw, la, ls, ld, st);
            end else begin
                v  = ($urandom_range(0, 2) != 0);
                wr = ($urandom_range(0, 2) == 0);
                sz = 2'($urandom_range(0, 2));
                a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31) * 4);
                if (sz == 2'd0) a = a | 32'($urandom_range(0, 3));
                if (sz == 2'd1) a = a | 32'($urandom_range(0, 1) * 2);
                d  = $urandom;
                step(v, wr, a, sz, d, st);
            end
        end
        idle(LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mr1_mem_port_model.md
# mr1_mem_port_model

Parametrised, synthesizable memory-port responder for MR1 core benches and formal harnesses. One instance serves one MR1 valid/ready request port plus its valid-only response port: instruction fetch with WR_EN=0, data with WR_EN=1. It replaces free-running environment inputs with a bounded model that has:
- fixed response latency;
- a cap on outstanding reads;
- externally driven back-pressure;
- byte-lane writes;
- a sticky protocol-error flag.

## Interface
Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width; must be 32
- MEM_WORDS, 256, backing store depth in words; power of two
- LATENCY, 2, cycles from read acceptance to response; 1..8
- DEPTH, 2, maximum outstanding reads; 1..8
- WR_EN, 1, 0 disables writes: any accepted write sets err

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  forces req_ready low this cycle (back-pressure injection)
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid & ready
- req_addr  in  ADDR_W  byte address
- req_wr  in  1  1 = write, 0 = read
- req_size  in  2  0 byte, 1 half, 2 word
- req_data  in  DATA_W  write data, little-endian, lane-aligned per addr[1:0]
- rsp_valid  out  1  read response valid, single-cycle pulse
- rsp_data  out  DATA_W  full aligned word
- outstanding  out  4  accepted reads not yet answered
- err  out  1  sticky protocol error

## Operation
- Accept: `acc = req_valid & req_ready`.
- Ready: `req_ready = !stall & (req_wr | outstanding < DEPTH)`.
  - Outstanding is the registered count; a response leaving in the same cycle does not free a slot.
- Read accept:
  - The word at `mem[req_addr[2 +: log2(MEM_WORDS)]]` is sampled in the accept cycle.
  - That value plus a valid bit enters a LATENCY-stage delay line.
  - Upper address bits are ignored (address wraps modulo memory size).
- Write accept:
  - Byte-enable mask: size 0 -> `1 << a[1:0]`, size 1 -> `3 << a[1:0]`, size 2 -> 4'hF.
  - Masked lanes of `req_data` are written at the clock edge.
  - No response is produced.
- Read-after-write: a read accepted the cycle after a write sees the new data. A read in the same cycle cannot occur (one request per cycle).
- Outstanding counter:
  - +1 on read accept, -1 on `rsp_valid`.
  - Both in the same cycle: net 0.
- err is set and held (cleared only by reset) on any of:
  - misalignment: size 1 with `a[0]=1`, or size 2 with `a[1:0]!=0`; the access is still performed with the computed mask;
  - size 3; treated as word;
  - valid withdrawn: req_valid high & !req_ready in cycle N, but req_valid low in cycle N+1;
  - request changed while stalled: addr, wr, size or data (data checked for writes) differs between cycle N and N+1 of a stalled request;
  - a write accepted when WR_EN=0; the memory is not modified;
  - rsp_valid while outstanding==0; internal consistency check.
- Memory contents are not reset; reading an unwritten word returns X in simulation and is unconstrained in formal.

## Timing
- Reset values:
  - req_ready 0 while reset_n low;
  - rsp_valid 0, rsp_data 0, outstanding 0, err 0;
  - delay line cleared.
- Reset asserted mid-operation: all in-flight responses are dropped immediately, with no late rsp after reset release.
- Read latency: accepted in cycle N -> rsp_valid in cycle N+LATENCY.
- Responses are strictly in acceptance order.
- Throughput: one read per cycle when DEPTH >= LATENCY+1; otherwise at most DEPTH reads per LATENCY+1 cycles.
- stall has combinational effect on req_ready in the same cycle. All other outputs are registered.

## Structure
- Package mr1_mem_pkg:
  - size enum: SIZE_B=0, SIZE_H=1, SIZE_W=2;
  - function `byte_mask(size, addr_lo)`;
  - function `misaligned(size, addr_lo)`.
- Sub-module mr1_rsp_delay_line:
  - parameters LATENCY and DATA_W;
  - valid/data shift register with async clear.
- Top module holds: memory array, outstanding counter, previous-cycle request capture for the err checks.

## Test plan
- Word write then read: write 0xDEADBEEF to 0x10 in cycle 0; read 0x10 accepted in cycle 1 with LATENCY=2 -> rsp_valid in cycle 3 with 0xDEADBEEF; outstanding 1 in cycles 2-3, 0 in cycle 4.
- Byte lanes: word 0 at 0x20, then byte 0xAA to 0x22, then half 0x1234 to 0x20 -> read returns 0x00AA1234; err stays 0.
- Outstanding cap: DEPTH=2, LATENCY=4, back-to-back reads -> req_ready low in cycles 2-4 and high again in cycle 5; responses arrive in cycles 4 and 5, in order.
- Stall protocol: hold read 0x40 under stall for 3 cycles, then drop req_valid while still stalled -> err=1 in the next cycle and stays 1; in a separate run, changing addr under stall -> err=1.
- Misaligned access: word read at 0x42 -> err=1; the response still arrives after LATENCY cycles with the word at 0x40.
- Reset mid-flight: three reads accepted, reset_n pulsed low for 1 cycle before any response -> no rsp_valid afterwards, outstanding=0, err=0.
